reservation_station: RTL and testbench

- Out-of-order issue buffer for ALU/branch/jump ops; sits between dispatch and the execute stage.
- Holds dispatched instructions until both source operands are known, snooping the two CDB sources (execute result, load/store buffer result).
- Issues at most one ready instruction per cycle to execute as a registered bundle.
- Squashed wholesale on ROB rollback.

---
 rtl/reservation_station_pkg.sv | 84 ++++++++
 rtl/reservation_station_pick.sv | 23 ++
 rtl/reservation_station.sv | 138 +++++++++++++
 tb/tb_reservation_station.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared widths, op encodings and entry types for the reservation station.
package reservation_station_pkg;

    localparam int ADDR_W       = 32;
    localparam int OP_W         = 6;
    localparam int IMM_W        = 32;
    localparam int NICK_W       = 5;
    localparam int DATA_W       = 32;
    localparam int RS_SIZE_DEF  = 16;
    localparam int RS_IDX_W_DEF = 4;

    // Decoded op encodings. The station only carries these through to execute.
    localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
    localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
    localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
    localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
    localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
    localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
    localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
    localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
    localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
    localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
    localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
    localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
    localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
    localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
    localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
    localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
    localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
    localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
    localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
    localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
    localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
    localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
    localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
    localparam logic [OP_W-1:0] OP_OR    = 6'd36;
    localparam logic [OP_W-1:0] OP_AND   = 6'd37;

    // One source operand: either a known value or the ROB tag it waits on.
    typedef struct packed {
        logic              rdy;
        logic [DATA_W-1:0] val;
        logic [NICK_W-1:0] nick;
    } operand_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] pc;
        logic [IMM_W-1:0]  imm;
        logic [NICK_W-1:0] rd_nick;
        operand_t          src1;
        operand_t          src2;
    } rs_entry_t;

    // Wake a waiting operand from either CDB source; execute wins a tie.
    function automatic operand_t capture_operand(
        input operand_t          cur,
        input logic              ex_en,
        input logic [NICK_W-1:0] ex_nick,
        input logic [DATA_W-1:0] ex_dt,
        input logic              slb_en,
        input logic [NICK_W-1:0] slb_nick,
        input logic [DATA_W-1:0] slb_dt
    );
        operand_t res;
        res = cur;
        if (!cur.rdy) begin
            if (ex_en && (ex_nick == cur.nick)) begin
                res.rdy = 1'b1;
                res.val = ex_dt;
            end else if (slb_en && (slb_nick == cur.nick)) begin
                res.rdy = 1'b1;
                res.val = slb_dt;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_pick.sv
// Lowest-index priority encoder: returns the first set bit and whether any is set.
module rs_pick #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer: holds dispatched ALU/branch ops until both
// operands are known (snooping both CDBs) and issues one ready op per cycle.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int RS_SIZE  = RS_SIZE_DEF,
    parameter int RS_IDX_W = RS_IDX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iROB_clr,
    input  logic              iDP_en,
    input  logic [ADDR_W-1:0] iDP_pc,
    input  logic [OP_W-1:0]   iDP_op,
    input  logic [IMM_W-1:0]  iDP_imm,
    input  logic [NICK_W-1:0] iDP_rd_nick,
    input  logic              iDP_rs1_rdy,
    input  logic [DATA_W-1:0] iDP_rs1_dt,
    input  logic [NICK_W-1:0] iDP_rs1_nick,
    input  logic              iDP_rs2_rdy,
    input  logic [DATA_W-1:0] iDP_rs2_dt,
    input  logic [NICK_W-1:0] iDP_rs2_nick,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [DATA_W-1:0] iEX_dt,
    input  logic              iSLB_en,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [DATA_W-1:0] iSLB_dt,
    output logic              oRS_full,
    output logic              oRS_en,
    output logic [ADDR_W-1:0] oRS_pc,
    output logic [OP_W-1:0]   oRS_op,
    output logic [IMM_W-1:0]  oRS_imm,
    output logic [NICK_W-1:0] oRS_rd_nick,
    output logic [DATA_W-1:0] oRS_rs1_dt,
    output logic [DATA_W-1:0] oRS_rs2_dt
);

    logic [RS_SIZE-1:0]  busy;
    rs_entry_t           ent [RS_SIZE];
    logic [RS_SIZE-1:0]  free_vec;
    logic [RS_SIZE-1:0]  ready_vec;
    logic [RS_IDX_W-1:0] free_idx;
    logic [RS_IDX_W-1:0] issue_idx;
    logic                free_found;
    logic                issue_found;
    rs_entry_t           dp_entry;

    assign free_vec = ~busy;
    assign oRS_full = &busy;

    // Ready mask uses stored operand state only, so a same-cycle CDB wakeup
    // never feeds the issue mux directly.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy[i] & ent[i].src1.rdy & ent[i].src2.rdy;
        end
    end

    rs_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_pick_free (
        .vec   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_pick #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_pick_issue (
        .vec   (ready_vec),
        .idx   (issue_idx),
        .found (issue_found)
    );

    // Build the incoming entry, bypassing any CDB result that lands this cycle.
    always_comb begin
        dp_entry         = '0;
        dp_entry.op      = iDP_op;
        dp_entry.pc      = iDP_pc;
        dp_entry.imm     = iDP_imm;
        dp_entry.rd_nick = iDP_rd_nick;
        dp_entry.src1    = capture_operand('{rdy: iDP_rs1_rdy, val: iDP_rs1_dt, nick: iDP_rs1_nick},
                                           iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt);
        dp_entry.src2    = capture_operand('{rdy: iDP_rs2_rdy, val: iDP_rs2_dt, nick: iDP_rs2_nick},
                                           iEX_en, iEX_nick, iEX_dt, iSLB_en, iSLB_nick, iSLB_dt);
    end

    // Entry storage, CDB snoop, issue register and dispatch write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= '0;
            oRS_en      <= 1'b0;
            oRS_pc      <= '0;
            oRS_op      <= '0;
            oRS_imm     <= '0;
            oRS_rd_nick <= '0;
            oRS_rs1_dt  <= '0;
            oRS_rs2_dt  <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= '0;
            end
        end else if (rdy) begin
            if (iROB_clr) begin
                busy   <= '0;
                oRS_en <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        ent[i].src1 <= capture_operand(ent[i].src1, iEX_en, iEX_nick, iEX_dt,
                                                       iSLB_en, iSLB_nick, iSLB_dt);
                        ent[i].src2 <= capture_operand(ent[i].src2, iEX_en, iEX_nick, iEX_dt,
                                                       iSLB_en, iSLB_nick, iSLB_dt);
                    end
                end

                if (issue_found) begin
                    busy[issue_idx] <= 1'b0;
                    oRS_en          <= 1'b1;
                    oRS_pc          <= ent[issue_idx].pc;
                    oRS_op          <= ent[issue_idx].op;
                    oRS_imm         <= ent[issue_idx].imm;
                    oRS_rd_nick     <= ent[issue_idx].rd_nick;
                    oRS_rs1_dt      <= ent[issue_idx].src1.val;
                    oRS_rs2_dt      <= ent[issue_idx].src2.val;
                end else begin
                    oRS_en <= 1'b0;
                end

                // The free slot comes from the start-of-cycle busy vector, so a
                // same-cycle issue never makes room for this dispatch.
                if (iDP_en && free_found) begin
                    busy[free_idx] <= 1'b1;
                    ent[free_idx]  <= dp_entry;
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench: table vectors, hand sequences for multi-cycle corners,
// and randomized traffic against a slot-level behavioural model.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic              clk, rst, rdy, iROB_clr, iDP_en;
    logic [ADDR_W-1:0] iDP_pc;
    logic [OP_W-1:0]   iDP_op;
    logic [IMM_W-1:0]  iDP_imm;
    logic [NICK_W-1:0] iDP_rd_nick, iDP_rs1_nick, iDP_rs2_nick, iEX_nick, iSLB_nick;
    logic              iDP_rs1_rdy, iDP_rs2_rdy, iEX_en, iSLB_en;
    logic [DATA_W-1:0] iDP_rs1_dt, iDP_rs2_dt, iEX_dt, iSLB_dt;
    logic              oRS_full, oRS_en;
    logic [ADDR_W-1:0] oRS_pc;
    logic [OP_W-1:0]   oRS_op;
    logic [IMM_W-1:0]  oRS_imm;
    logic [NICK_W-1:0] oRS_rd_nick;
    logic [DATA_W-1:0] oRS_rs1_dt, oRS_rs2_dt;

    reservation_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iROB_clr(iROB_clr),
        .iDP_en(iDP_en), .iDP_pc(iDP_pc), .iDP_op(iDP_op), .iDP_imm(iDP_imm),
        .iDP_rd_nick(iDP_rd_nick),
        .iDP_rs1_rdy(iDP_rs1_rdy), .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs1_nick(iDP_rs1_nick),
        .iDP_rs2_rdy(iDP_rs2_rdy), .iDP_rs2_dt(iDP_rs2_dt), .iDP_rs2_nick(iDP_rs2_nick),
        .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
        .iSLB_en(iSLB_en), .iSLB_nick(iSLB_nick), .iSLB_dt(iSLB_dt),
        .oRS_full(oRS_full), .oRS_en(oRS_en), .oRS_pc(oRS_pc), .oRS_op(oRS_op),
        .oRS_imm(oRS_imm), .oRS_rd_nick(oRS_rd_nick),
        .oRS_rs1_dt(oRS_rs1_dt), .oRS_rs2_dt(oRS_rs2_dt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: slots with plain fields ----------------
    typedef struct {
        bit                busy;
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] pc;
        logic [IMM_W-1:0]  imm;
        logic [NICK_W-1:0] rd;
        bit                r1, r2;
        logic [DATA_W-1:0] v1, v2;
        logic [NICK_W-1:0] q1, q2;
    } m_ent_t;

    m_ent_t            m [16];
    bit                m_en;
    logic [ADDR_W-1:0] m_pc;
    logic [OP_W-1:0]   m_op;
    logic [IMM_W-1:0]  m_imm;
    logic [NICK_W-1:0] m_rd;
    logic [DATA_W-1:0] m_v1, m_v2;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m[i].busy = 0;
        m_en = 0; m_pc = 0; m_op = 0; m_imm = 0; m_rd = 0; m_v1 = 0; m_v2 = 0;
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 16; i++) if (m[i].busy) c++;
        return c;
    endfunction

    // An operand waiting on a tag picks up whichever broadcast carries that tag.
    task automatic m_wake(inout bit r, inout logic [DATA_W-1:0] v, input logic [NICK_W-1:0] q);
        if (r) return;
        if (iEX_en && iEX_nick == q) begin r = 1; v = iEX_dt; end
        else if (iSLB_en && iSLB_nick == q) begin r = 1; v = iSLB_dt; end
    endtask

    // One clock edge worth of behaviour, from the current input values.
    task automatic m_step();
        int issue = -1;
        int slot  = -1;
        if (!rdy) return;
        if (iROB_clr) begin
            for (int i = 0; i < 16; i++) m[i].busy = 0;
            m_en = 0;
            return;
        end
        for (int i = 0; i < 16; i++)
            if (issue < 0 && m[i].busy && m[i].r1 && m[i].r2) issue = i;
        if (iDP_en && m_count() < 16)
            for (int i = 0; i < 16; i++)
                if (slot < 0 && !m[i].busy) slot = i;
        for (int i = 0; i < 16; i++) begin
            if (m[i].busy) begin
                m_wake(m[i].r1, m[i].v1, m[i].q1);
                m_wake(m[i].r2, m[i].v2, m[i].q2);
            end
        end
        if (issue >= 0) begin
            m_en = 1; m_pc = m[issue].pc; m_op = m[issue].op; m_imm = m[issue].imm;
            m_rd = m[issue].rd; m_v1 = m[issue].v1; m_v2 = m[issue].v2;
            m[issue].busy = 0;
        end else begin
            m_en = 0;
        end
        if (slot >= 0) begin
            m[slot].busy = 1; m[slot].op = iDP_op; m[slot].pc = iDP_pc;
            m[slot].imm = iDP_imm; m[slot].rd = iDP_rd_nick;
            m[slot].r1 = iDP_rs1_rdy; m[slot].v1 = iDP_rs1_dt; m[slot].q1 = iDP_rs1_nick;
            m[slot].r2 = iDP_rs2_rdy; m[slot].v2 = iDP_rs2_dt; m[slot].q2 = iDP_rs2_nick;
            m_wake(m[slot].r1, m[slot].v1, m[slot].q1);
            m_wake(m[slot].r2, m[slot].v2, m[slot].q2);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        iROB_clr = 0; iDP_en = 0; iEX_en = 0; iSLB_en = 0;
        iDP_pc = 0; iDP_op = 0; iDP_imm = 0; iDP_rd_nick = 0;
        iDP_rs1_rdy = 0; iDP_rs1_dt = 0; iDP_rs1_nick = 0;
        iDP_rs2_rdy = 0; iDP_rs2_dt = 0; iDP_rs2_nick = 0;
        iEX_nick = 0; iEX_dt = 0; iSLB_nick = 0; iSLB_dt = 0;
    endtask

    task automatic disp(input logic [ADDR_W-1:0] pc, input logic [OP_W-1:0] op,
                        input logic [IMM_W-1:0] imm, input logic [NICK_W-1:0] rd,
                        input logic r1, input logic [DATA_W-1:0] v1, input logic [NICK_W-1:0] q1,
                        input logic r2, input logic [DATA_W-1:0] v2, input logic [NICK_W-1:0] q2);
        iDP_en = 1; iDP_pc = pc; iDP_op = op; iDP_imm = imm; iDP_rd_nick = rd;
        iDP_rs1_rdy = r1; iDP_rs1_dt = v1; iDP_rs1_nick = q1;
        iDP_rs2_rdy = r2; iDP_rs2_dt = v2; iDP_rs2_nick = q2;
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_bundle(input string tag, input logic [ADDR_W-1:0] pc,
                                input logic [OP_W-1:0] op, input logic [NICK_W-1:0] rd,
                                input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
        check({tag, ".en"},  oRS_en, 1);
        check({tag, ".pc"},  oRS_pc, pc);
        check({tag, ".op"},  oRS_op, op);
        check({tag, ".rd"},  oRS_rd_nick, rd);
        check({tag, ".rs1"}, oRS_rs1_dt, v1);
        check({tag, ".rs2"}, oRS_rs2_dt, v2);
    endtask

    // ---------------- single-dispatch vector table ----------------
    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [OP_W-1:0]   op;
        logic [IMM_W-1:0]  imm;
        logic [NICK_W-1:0] rd;
        logic r1; logic [DATA_W-1:0] v1; logic [NICK_W-1:0] q1;
        logic r2; logic [DATA_W-1:0] v2; logic [NICK_W-1:0] q2;
        logic ex_en;  logic [NICK_W-1:0] ex_q;  logic [DATA_W-1:0] ex_d;
        logic slb_en; logic [NICK_W-1:0] slb_q; logic [DATA_W-1:0] slb_d;
        logic exp_issue; logic [DATA_W-1:0] exp_v1, exp_v2;
    } vec_t;

    vec_t vt [8];

    initial begin
        int got;
        logic [ADDR_W-1:0] pcs [$];

        // pc, op, imm, rd, r1,v1,q1, r2,v2,q2, ex, slb, expected
        vt[0] = '{32'h100, OP_ADD,  32'h0,  5'd3,  1, 32'd5, 5'd0,  1, 32'd7, 5'd0,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 32'd5, 32'd7};
        vt[1] = '{32'h104, OP_SUB,  32'h0,  5'd4,  1, 32'd1, 5'd0,  0, 32'd0, 5'd6,
                  0, 5'd0, 32'h0, 1, 5'd6, 32'hABCD, 1, 32'd1, 32'hABCD};
        vt[2] = '{32'h108, OP_ADDI, 32'h8,  5'd5,  0, 32'd0, 5'd2,  1, 32'd0, 5'd0,
                  1, 5'd2, 32'h10, 0, 5'd0, 32'h0, 1, 32'h10, 32'd0};
        vt[3] = '{32'h10C, OP_XOR,  32'h0,  5'd6,  0, 32'd0, 5'd4,  0, 32'd0, 5'd5,
                  1, 5'd4, 32'h11, 1, 5'd5, 32'h22, 1, 32'h11, 32'h22};
        vt[4] = '{32'h110, OP_AND,  32'h0,  5'd7,  0, 32'd0, 5'd7,  0, 32'd0, 5'd7,
                  1, 5'd7, 32'h33, 1, 5'd7, 32'h44, 1, 32'h33, 32'h33};
        vt[5] = '{32'h114, OP_OR,   32'h0,  5'd8,  0, 32'd0, 5'd1,  1, 32'd9, 5'd0,
                  1, 5'd2, 32'h55, 0, 5'd0, 32'h0, 0, 32'd0, 32'd0};
        vt[6] = '{32'h118, OP_LUI,  32'h12345000, 5'd9, 1, 32'd0, 5'd0, 1, 32'd0, 5'd0,
                  0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 32'd0, 32'd0};
        vt[7] = '{32'h11C, OP_BEQ,  32'h40, 5'd10, 1, 32'h66, 5'd3, 1, 32'h77, 5'd3,
                  1, 5'd3, 32'h99, 1, 5'd3, 32'h88, 1, 32'h66, 32'h77};

        rst = 0; rdy = 1; idle(); m_reset();
        @(negedge clk); @(negedge clk);
        check("reset.en",   oRS_en, 0);
        check("reset.full", oRS_full, 0);
        check("reset.pc",   oRS_pc, 0);
        check("reset.rs1",  oRS_rs1_dt, 0);
        check("reset.rs2",  oRS_rs2_dt, 0);
        check("reset.imm",  oRS_imm, 0);
        rst = 1;

        for (int k = 0; k < 8; k++) begin
            string t;
            t = $sformatf("vec%0d", k);
            disp(vt[k].pc, vt[k].op, vt[k].imm, vt[k].rd, vt[k].r1, vt[k].v1, vt[k].q1,
                 vt[k].r2, vt[k].v2, vt[k].q2);
            iEX_en = vt[k].ex_en;   iEX_nick = vt[k].ex_q;   iEX_dt = vt[k].ex_d;
            iSLB_en = vt[k].slb_en; iSLB_nick = vt[k].slb_q; iSLB_dt = vt[k].slb_d;
            tick();
            idle();
            check({t, ".edge1_en"}, oRS_en, 0);
            tick();
            check({t, ".edge2_en"}, oRS_en, vt[k].exp_issue);
            if (vt[k].exp_issue) begin
                check_bundle(t, vt[k].pc, vt[k].op, vt[k].rd, vt[k].exp_v1, vt[k].exp_v2);
                check({t, ".imm"}, oRS_imm, vt[k].imm);
            end
            tick();
            check({t, ".edge3_en"}, oRS_en, 0);
            iROB_clr = 1; tick(); idle();
        end

        // Waiting operand: no issue until the execute broadcast, then one edge later.
        disp(32'h200, OP_ADDI, 32'h1, 5'd11, 0, 0, 5'd2, 1, 0, 0);
        tick(); idle();
        check("wake.pre0", oRS_en, 0);
        tick();
        check("wake.pre1", oRS_en, 0);
        iEX_en = 1; iEX_nick = 5'd2; iEX_dt = 32'h10;
        tick(); idle();
        check("wake.capture_edge", oRS_en, 0);
        tick();
        check_bundle("wake", 32'h200, OP_ADDI, 5'd11, 32'h10, 32'h0);

        // Fill all 16 slots waiting on tag 9, then a dropped 17th.
        for (int i = 0; i < 16; i++) begin
            disp(32'h400 + 4 * i, OP_ADD, 0, 5'(i), 0, 0, 5'd9, 1, 32'(i), 0);
            tick();
            check($sformatf("fill%0d.full", i), oRS_full, (i == 15));
        end
        disp(32'hDEAD, OP_ADD, 0, 5'd1, 1, 1, 0, 1, 1, 0);
        tick(); idle();
        check("fill.drop_full", oRS_full, 1);
        check("fill.drop_en", oRS_en, 0);
        iEX_en = 1; iEX_nick = 5'd9; iEX_dt = 32'h99;
        tick(); idle();
        got = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (oRS_en) begin
                pcs.push_back(oRS_pc);
                if (got == 0) check("fill.full_after_first_issue", oRS_full, 0);
                got++;
            end
        end
        check("fill.issue_count", got, 16);
        for (int i = 0; i < 16 && i < pcs.size(); i++)
            check($sformatf("fill.order%0d", i), pcs[i], 32'h400 + 4 * i);

        // Rollback together with a dispatch: nothing survives.
        for (int i = 0; i < 4; i++) begin
            disp(32'h500 + 4 * i, OP_SUB, 0, 5'd20, 0, 0, 5'd12, 1, 0, 0);
            tick();
        end
        disp(32'h999, OP_ADD, 0, 5'd21, 1, 3, 0, 1, 4, 0);
        iROB_clr = 1;
        tick(); idle();
        check("clr.en", oRS_en, 0);
        check("clr.full", oRS_full, 0);
        iEX_en = 1; iEX_nick = 5'd12; iEX_dt = 32'h1;
        tick(); idle();
        got = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (oRS_en) got++;
        end
        check("clr.no_issue", got, 0);

        // rdy low freezes everything, including a pending issue.
        disp(32'h600, OP_OR, 0, 5'd1, 1, 32'hA1, 0, 1, 32'hA2, 0);
        tick();
        disp(32'h604, OP_OR, 0, 5'd2, 1, 32'hB1, 0, 1, 32'hB2, 0);
        tick(); idle();
        check_bundle("hold.first", 32'h600, OP_OR, 5'd1, 32'hA1, 32'hA2);
        rdy = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("hold%0d.en", c), oRS_en, 1);
            check($sformatf("hold%0d.pc", c), oRS_pc, 32'h600);
        end
        rdy = 1;
        tick();
        check_bundle("hold.second", 32'h604, OP_OR, 5'd2, 32'hB1, 32'hB2);

        // Asynchronous reset mid-cycle, observed before the next edge.
        #2 rst = 0;
        #1;
        check("areset.en",  oRS_en, 0);
        check("areset.pc",  oRS_pc, 0);
        check("areset.rs1", oRS_rs1_dt, 0);
        check("areset.rd",  oRS_rd_nick, 0);
        m_reset();
        @(negedge clk);
        rst = 1;

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            check("rand.en",   oRS_en, m_en);
            check("rand.full", oRS_full, (m_count() == 16));
            check("rand.pc",   oRS_pc, m_pc);
            check("rand.op",   oRS_op, m_op);
            check("rand.imm",  oRS_imm, m_imm);
            check("rand.rd",   oRS_rd_nick, m_rd);
            check("rand.rs1",  oRS_rs1_dt, m_v1);
            check("rand.rs2",  oRS_rs2_dt, m_v2);
            idle();
            rdy      = ($urandom_range(0, 9) != 0);
            iROB_clr = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 9) < 6)
                disp($urandom, OP_W'($urandom_range(0, 37)), $urandom, NICK_W'($urandom),
                     $urandom_range(0, 1), $urandom, NICK_W'($urandom_range(0, 7)),
                     $urandom_range(0, 1), $urandom, NICK_W'($urandom_range(0, 7)));
            iEX_en  = ($urandom_range(0, 9) < 3);
            iEX_nick = NICK_W'($urandom_range(0, 7)); iEX_dt = $urandom;
            iSLB_en = ($urandom_range(0, 9) < 3);
            iSLB_nick = NICK_W'($urandom_range(0, 7)); iSLB_dt = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
